pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter RegAddrWidth, default 5, meaning register address width.
REQ-002 SHALL have parameter McTimeout, default 64, meaning max cycles a multi-cycle EX op may stay busy.
REQ-003 SHALL have parameter CntWidth, default 16, meaning stall-counter width.
REQ-004 SHALL have ports (name  direction  width  meaning):
- iClk  in  1  clock; one clock, all state on rising edge.
- nRst  in  1  reset; synchronous, active-low.
- iIdValid  in  1  ID holds a valid instruction.
- iIdRs1Addr, iIdRs2Addr  in  RegAddrWidth  ID source addresses, zero when unused.
- iIdBranch  in  1  ID instruction is a conditional branch.
- iBrTrue  in  1  ID branch/jump resolved taken.
- iExValid, iExWbEn, iExLoad  in  1 each  EX valid, writes rd, is a load.
- iExRdAddr  in  RegAddrWidth  EX destination.
- iExMcStart  in  1  EX begins multi-cycle op (1-cycle pulse).
- iExMcDone  in  1  multi-cycle op result ready (1-cycle pulse).
- iMemBusy  in  1  data memory not ready (level).
- oStallIF, oStallID, oStallEX, oStallMEM  out  1 each  hold stage register.
- oBubbleEX  out  1  load NOP into ID/EX register.
- oFlushIF  out  1  squash IF/ID register.
- oFault  out  1  multi-cycle timeout, sticky.
- oState  out  3  current FSM state encoding.
- oStallCnt  out  CntWidth  cycles with oStallID=1.

Function
REQ-005 SHALL implement FSM states RUN=0, MCW=1, MEMW=2, FAULT=3; other encodings unused.
REQ-006 SHALL define hit(x) = iExValid & iExWbEn & (iExRdAddr!=0) & (iExRdAddr==x), x = iIdRs1Addr or iIdRs2Addr.
REQ-007 SHALL, in RUN, detect load-use = iIdValid & iExLoad & (hit(rs1)|hit(rs2)); combinationally assert oStallIF, oStallID, oBubbleEX the same cycle.
REQ-008 SHALL, in RUN, detect branch-operand = iIdValid & iIdBranch & ~iExLoad & (hit(rs1)|hit(rs2)); same response as REQ-007 for that cycle.
REQ-009 SHALL, in RUN with no REQ-007/008 hazard, assert oFlushIF when iIdValid & iBrTrue; no stall.
REQ-010 SHALL suppress oFlushIF whenever oStallID=1 (branch re-resolves next cycle).
REQ-011 SHALL move RUN->MCW on iExMcStart, unless iExMcDone is high the same cycle (remain RUN).
REQ-012 SHALL, in MCW, assert oStallIF, oStallID, oStallEX; oBubbleEX=0, oFlushIF=0.
REQ-013 SHALL move MCW->RUN on iExMcDone; stall outputs deassert the cycle after.
REQ-014 SHALL count MCW cycles in a timeout counter cleared on MCW entry; when it reaches McTimeout without iExMcDone, go to FAULT.
REQ-015 SHALL, in any state except FAULT, go to MEMW when iMemBusy=1 (priority over REQ-011/013); remember whether MCW was active.
REQ-016 SHALL, in MEMW, assert all four oStall* and no bubble/flush; on iMemBusy=0 return to MCW if remembered (timeout counter frozen, not cleared), else RUN.
REQ-017 SHALL, in FAULT, assert all four oStall* and oFault; exit only by reset.
REQ-018 SHALL increment oStallCnt each cycle oStallID=1, saturating at all-ones.
REQ-019 SHALL register only state, MCW flag, timeout counter, oStallCnt; all other outputs combinational from state and inputs.

Reset
REQ-020 SHALL, on rising iClk with nRst=0, set state RUN, clear MCW flag, timeout counter, oStallCnt, oFault; mid-operation reset in MCW/MEMW/FAULT has the same effect.
REQ-021 SHALL, while nRst=0, drive all oStall*, oBubbleEX, oFlushIF low and oState=0.

Verification
REQ-022 Load-use: EX lw rd=5, ID add rs1=5 -> 1 cycle oStallIF=oStallID=oBubbleEX=1, oStallCnt 0->1; rd=0 variant -> no stall.
REQ-023 Branch: ID beq taken, no hazard -> oFlushIF=1 one cycle; same with EX addi rd=rs2 -> stall 1 cycle, flush next cycle.
REQ-024 Multi-cycle: iExMcStart, iExMcDone 10 cycles later -> oState=1 for 10 cycles, then 0; oStallCnt=10.
REQ-025 Mem during MCW: iMemBusy high 3 cycles mid-MCW -> oState=2, all stalls set, then back to 1; iExMcDone then -> 0.
REQ-026 Timeout and reset: McTimeout=8, no done -> oState=3, oFault=1 sticky; nRst low one edge -> oState=0, oFault=0, oStallCnt=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: ID/EX hazard detection plus multi-cycle EX and data-memory stall sequencing.
module pipe_hazard_ctrl #(
    parameter int RegAddrWidth = 5,
    parameter int McTimeout    = 64,
    parameter int CntWidth     = 16
) (
    input  logic                    iClk,
    input  logic                    nRst,
    input  logic                    iIdValid,
    input  logic [RegAddrWidth-1:0] iIdRs1Addr,
    input  logic [RegAddrWidth-1:0] iIdRs2Addr,
    input  logic                    iIdBranch,
    input  logic                    iBrTrue,
    input  logic                    iExValid,
    input  logic                    iExWbEn,
    input  logic                    iExLoad,
    input  logic [RegAddrWidth-1:0] iExRdAddr,
    input  logic                    iExMcStart,
    input  logic                    iExMcDone,
    input  logic                    iMemBusy,
    output logic                    oStallIF,
    output logic                    oStallID,
    output logic                    oStallEX,
    output logic                    oStallMEM,
    output logic                    oBubbleEX,
    output logic                    oFlushIF,
    output logic                    oFault,
    output logic [2:0]              oState,
    output logic [CntWidth-1:0]     oStallCnt
);
    typedef enum logic [2:0] {RUN = 3'd0, MCW = 3'd1, MEMW = 3'd2, FAULT = 3'd3} state_t;
    localparam int ToWidth = $clog2(McTimeout + 1);
    state_t             state;
    logic               mc_flag;
    logic [ToWidth-1:0] to_cnt;
    logic               hit1, hit2, hazard, run, mc_go;
    always_comb begin
        hit1   = iExValid && iExWbEn && iExRdAddr != '0 && iExRdAddr == iIdRs1Addr;
        hit2   = iExValid && iExWbEn && iExRdAddr != '0 && iExRdAddr == iIdRs2Addr;
        hazard = iIdValid && (hit1 || hit2) && (iExLoad || iIdBranch);
        run    = nRst && state == RUN;
        mc_go  = iExMcStart && !iExMcDone;
    end
    // Outputs are forced quiet while reset is held, regardless of the registered state.
    assign oStallIF  = nRst && (state != RUN || hazard);
    assign oStallID  = oStallIF;
    assign oStallEX  = nRst && state != RUN;
    assign oStallMEM = nRst && (state == MEMW || state == FAULT);
    assign oBubbleEX = run && hazard;
    assign oFlushIF  = run && !hazard && iIdValid && iBrTrue;
    assign oFault    = nRst && state == FAULT;
    assign oState    = nRst ? state : RUN;
    always_ff @(posedge iClk) begin
        if (!nRst) begin
            state     <= RUN;
            mc_flag   <= 1'b0;
            to_cnt    <= '0;
            oStallCnt <= '0;
        end else begin
            if (oStallID && !(&oStallCnt)) oStallCnt <= oStallCnt + CntWidth'(1);
            case (state)
                RUN: begin
                    mc_flag <= mc_go;
                    to_cnt  <= '0;
                    state   <= iMemBusy ? MEMW : mc_go ? MCW : RUN;
                end
                MCW: begin
                    // >= so a timeout reached while detoured through MEMW still fires on return
                    mc_flag <= !iExMcDone;
                    to_cnt  <= to_cnt + ToWidth'(1);
                    state   <= iMemBusy ? MEMW : iExMcDone ? RUN :
                               (to_cnt >= ToWidth'(McTimeout - 1)) ? FAULT : MCW;
                end
                MEMW: begin
                    mc_flag <= mc_flag && !iExMcDone;
                    state   <= iMemBusy ? MEMW : (mc_flag && !iExMcDone) ? MCW : RUN;
                end
                default: state <= FAULT;
            endcase
        end
    end
endmodule
